synapse_request_gen: RTL and testbench

- Initiator side of the left-to-right activation protocol. Accepts spike events from left-layer neurons and looks up each neuron's fan-out mask in a local connectivity register file.
- Emits one (L, R) request pair per connected right neuron, serially, over a valid/ready handshake.
- Feeds the register-activation controller that drives the coefficient register layer.

---
 rtl/synapse_request_gen.sv | 209 ++++++++++++++++++++
 tb/tb_synapse_request_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/synapse_request_gen.sv
// Spike-driven request generator: queues left-layer spikes, snapshots each neuron's
// fan-out mask on pop and serially emits one (L, R) pair per connected right neuron.
module synapse_request_gen #(
  parameter int N_LEFT     = 8,
  parameter int N_RIGHT    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = $clog2(N_LEFT),
  parameter int RW         = $clog2(N_RIGHT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spike_valid,
  input  logic [LW-1:0]      spike_idx,
  output logic               spike_ready,
  input  logic               cfg_we,
  input  logic [LW-1:0]      cfg_row,
  input  logic [N_RIGHT-1:0] cfg_mask,
  output logic               req_valid,
  output logic [LW-1:0]      req_l,
  output logic [RW-1:0]      req_r,
  input  logic               req_ready,
  output logic               fanout_done,
  output logic               busy
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0]   DEPTH_C  = (FW+1)'(FIFO_DEPTH);
  localparam logic [FW:0]   CNT_ZERO = (FW+1)'(0);
  localparam logic [FW:0]   CNT_ONE  = (FW+1)'(1);
  localparam logic [FW-1:0] PTR_ONE  = FW'(1);
  localparam logic [RW-1:0] R_ZERO   = RW'(0);
  localparam logic [RW-1:0] R_ONE    = RW'(1);
  localparam logic [RW-1:0] R_LAST   = RW'(N_RIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      r_ptr_q, r_ptr_d;
  logic [LW-1:0]      cur_l_q, cur_l_d;
  logic [N_RIGHT-1:0] cur_mask_q, cur_mask_d;
  logic               req_valid_q, req_valid_d;
  logic [LW-1:0]      req_l_q, req_l_d;
  logic [RW-1:0]      req_r_q, req_r_d;
  logic               fanout_done_q, fanout_done_d;

  logic [LW-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [LW-1:0]      fifo_mem_d [FIFO_DEPTH];
  logic [FW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FW:0]        cnt_q, cnt_d;

  logic [N_RIGHT-1:0] row_q [N_LEFT];
  logic [N_RIGHT-1:0] row_d [N_LEFT];

  logic               spike_in_range;
  logic               cfg_in_range;
  logic               push;
  logic               pop;
  logic [LW-1:0]      head;

  // Out-of-range indices only exist when N_LEFT is not a power of two.
  if (N_LEFT == (1 << LW)) begin : g_full_range
    assign spike_in_range = 1'b1;
    assign cfg_in_range   = 1'b1;
  end else begin : g_part_range
    localparam logic [LW:0] LIM = (LW+1)'(N_LEFT);
    assign spike_in_range = ({1'b0, spike_idx} < LIM);
    assign cfg_in_range   = ({1'b0, cfg_row} < LIM);
  end

  assign spike_ready = (cnt_q != DEPTH_C);
  assign push        = spike_valid && spike_ready && spike_in_range;
  assign pop         = (state_q == S_IDLE) && (cnt_q != CNT_ZERO);
  assign head        = fifo_mem_q[rd_ptr_q];

  // Spike queue: pointers wrap naturally, occupancy counter decides full/empty.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = spike_idx;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    row_d = row_q;
    if (cfg_we && cfg_in_range) begin
      row_d[cfg_row] = cfg_mask;
    end else begin
      row_d = row_q;
    end
  end

  // Fan-out FSM; the mask snapshot reads row_q, so a same-edge write is not seen.
  always_comb begin
    state_d       = state_q;
    r_ptr_d       = r_ptr_q;
    cur_l_d       = cur_l_q;
    cur_mask_d    = cur_mask_q;
    req_valid_d   = 1'b0;
    req_l_d       = req_l_q;
    req_r_d       = req_r_q;
    fanout_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cur_l_d    = head;
          cur_mask_d = row_q[head];
          r_ptr_d    = R_ZERO;
          state_d    = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (cur_mask_q[r_ptr_q]) begin
          req_valid_d = 1'b1;
          req_l_d     = cur_l_q;
          req_r_d     = r_ptr_q;
          state_d     = S_EMIT;
        end else if (r_ptr_q == R_LAST) begin
          fanout_done_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          r_ptr_d = r_ptr_q + R_ONE;
        end
      end
      S_EMIT: begin
        if (req_ready) begin
          if (r_ptr_q == R_LAST) begin
            fanout_done_d = 1'b1;
            state_d       = S_DONE;
          end else begin
            r_ptr_d = r_ptr_q + R_ONE;
            state_d = S_SCAN;
          end
        end else begin
          req_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, queue and connectivity registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      r_ptr_q       <= R_ZERO;
      cur_l_q       <= {LW{1'b0}};
      cur_mask_q    <= {N_RIGHT{1'b0}};
      req_valid_q   <= 1'b0;
      req_l_q       <= {LW{1'b0}};
      req_r_q       <= {RW{1'b0}};
      fanout_done_q <= 1'b0;
      fifo_mem_q    <= '{default: {LW{1'b0}}};
      wr_ptr_q      <= {FW{1'b0}};
      rd_ptr_q      <= {FW{1'b0}};
      cnt_q         <= CNT_ZERO;
      row_q         <= '{default: {N_RIGHT{1'b0}}};
    end else begin
      state_q       <= state_d;
      r_ptr_q       <= r_ptr_d;
      cur_l_q       <= cur_l_d;
      cur_mask_q    <= cur_mask_d;
      req_valid_q   <= req_valid_d;
      req_l_q       <= req_l_d;
      req_r_q       <= req_r_d;
      fanout_done_q <= fanout_done_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_l       = req_l_q;
  assign req_r       = req_r_q;
  assign fanout_done = fanout_done_q;
  assign busy        = (state_q != S_IDLE) || (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_synapse_request_gen.sv
// Directed bench for synapse_request_gen: each task drives one scenario and checks
// the emitted (L, R) pairs, handshake timing and status flags against hand values.
module tb_synapse_request_gen;

  localparam int LW = 3;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spike_valid = 1'b0;
  logic [LW-1:0] spike_idx = 3'd0;
  logic          spike_ready;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_row = 3'd0;
  logic [7:0]    cfg_mask = 8'h00;
  logic          req_valid;
  logic [LW-1:0] req_l;
  logic [RW-1:0] req_r;
  logic          req_ready = 1'b0;
  logic          fanout_done;
  logic          busy;

  int tests = 0;
  int fails = 0;
  logic [5:0] got_q[$];
  logic [5:0] exp_q[$];
  int hs_q[$];
  int done_cnt;
  int first_valid;
  bit bad;

  synapse_request_gen #(.N_LEFT(8), .N_RIGHT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_mask(cfg_mask),
    .req_valid(req_valid), .req_l(req_l), .req_r(req_r), .req_ready(req_ready),
    .fanout_done(fanout_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] mask);
    cfg_we = 1'b1; cfg_row = row; cfg_mask = mask;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send_spike(input logic [2:0] idx);
    spike_valid = 1'b1; spike_idx = idx;
    tick();
    spike_valid = 1'b0;
  endtask

  // Runs a fixed number of cycles as the downstream sink, stalling each pair.
  task automatic collect(input int cycles, input int stall);
    int wait_n;
    logic [2:0] hold_l;
    logic [2:0] hold_r;
    bit stalled;
    wait_n = 0; hold_l = 3'd0; hold_r = 3'd0; stalled = 1'b0;
    got_q.delete(); hs_q.delete(); done_cnt = 0; first_valid = -1;
    for (int i = 0; i < cycles; i++) begin
      if (fanout_done === 1'b1) done_cnt++;
      if (stalled) begin
        tests++;
        if (req_valid !== 1'b1) begin
          fails++; $display("FAIL valid_hold: req_valid=%b required 1 at cycle %0d", req_valid, i);
        end
      end
      if (req_valid === 1'b1) begin
        if (first_valid < 0) first_valid = i;
        if (wait_n == 0) begin
          hold_l = req_l; hold_r = req_r;
        end else begin
          tests++;
          if (req_l !== hold_l || req_r !== hold_r) begin
            fails++; $display("FAIL pair_stable: (%0d,%0d) required (%0d,%0d)", req_l, req_r, hold_l, hold_r);
          end
        end
        if (wait_n >= stall) begin
          req_ready = 1'b1; got_q.push_back({req_l, req_r}); hs_q.push_back(i);
          wait_n = 0; stalled = 1'b0;
        end else begin
          req_ready = 1'b0; wait_n++; stalled = 1'b1;
        end
      end else begin
        req_ready = (stall == 0); stalled = 1'b0;
      end
      tick();
    end
    req_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b required 0", req_valid); end
    tests++; if (fanout_done !== 1'b0) begin fails++; $display("FAIL rst_fanout_done: got %b required 0", fanout_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests++; if (spike_ready !== 1'b1) begin fails++; $display("FAIL rst_spike_ready: got %b required 1", spike_ready); end
    send_spike(3'd3);
    collect(20, 0);
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rst_row_zero: got %0d pairs required 0", got_q.size()); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rst_zero_done: got %0d pulses required 1", done_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_end_busy: got %b required 0", busy); end
  endtask

  task automatic test_basic();
    req_ready = 1'b0;
    write_row(3'd2, 8'b1000_0101);
    send_spike(3'd2);
    collect(40, 0);
    exp_q = '{6'o20, 6'o22, 6'o27};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL basic_pairs: got %p required %p", got_q, exp_q); end
    tests++; if (first_valid != 2) begin fails++; $display("FAIL basic_latency: first valid at %0d required 2", first_valid); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL basic_done: got %0d pulses required 1", done_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    req_ready = 1'b0;
    send_spike(3'd2);
    collect(80, 5);
    exp_q = '{6'o20, 6'o22, 6'o27};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL bp_pairs: got %p required %p", got_q, exp_q); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL bp_done: got %0d pulses required 1", done_cnt); end
  endtask

  task automatic test_fifo_full();
    req_ready = 1'b0;
    write_row(3'd1, 8'h01); write_row(3'd4, 8'h02); write_row(3'd5, 8'h04);
    write_row(3'd6, 8'h08); write_row(3'd7, 8'h10);
    send_spike(3'd2);
    tick(); tick();
    tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL full_stuck_valid: got %b required 1", req_valid); end
    send_spike(3'd1); send_spike(3'd4); send_spike(3'd5);
    tests++; if (spike_ready !== 1'b1) begin fails++; $display("FAIL full_three_ready: got %b required 1", spike_ready); end
    send_spike(3'd6);
    tests++; if (spike_ready !== 1'b0) begin fails++; $display("FAIL full_four_ready: got %b required 0", spike_ready); end
    send_spike(3'd7);
    tests++; if (spike_ready !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL full_drop_flags: spike_ready=%b busy=%b required 0/1", spike_ready, busy);
    end
    collect(200, 0);
    exp_q = '{6'o20, 6'o22, 6'o27, 6'o10, 6'o41, 6'o52, 6'o63};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL full_order: got %p required %p", got_q, exp_q); end
    tests++; if (done_cnt != 5) begin fails++; $display("FAIL full_done: got %0d pulses required 5", done_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy: got %b required 0", busy); end
  endtask

  task automatic test_config_hazard();
    req_ready = 1'b0;
    send_spike(3'd2);
    tick();
    write_row(3'd2, 8'hFF);
    collect(60, 0);
    exp_q = '{6'o20, 6'o22, 6'o27};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL hazard_snapshot: got %p required %p", got_q, exp_q); end
    send_spike(3'd2);
    write_row(3'd2, 8'h40);
    collect(60, 0);
    exp_q = '{6'o20, 6'o21, 6'o22, 6'o23, 6'o24, 6'o25, 6'o26, 6'o27};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL hazard_full_mask: got %p required %p", got_q, exp_q); end
    tests++; bad = (hs_q.size() != 8);
    for (int k = 0; k < hs_q.size() && !bad; k++) bad = (hs_q[k] != 1 + 2 * k);
    if (bad) begin fails++; $display("FAIL b2b_cadence: handshake cycles %p required 1,3,..,15", hs_q); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL hazard_done: got %0d pulses required 1", done_cnt); end
    send_spike(3'd2);
    collect(40, 0);
    exp_q = '{6'o26};
    tests++; bad = (got_q.size() != exp_q.size());
    for (int k = 0; k < got_q.size() && !bad; k++) bad = (got_q[k] !== exp_q[k]);
    if (bad) begin fails++; $display("FAIL hazard_same_edge: got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    write_row(3'd2, 8'b1000_0101);
    send_spike(3'd2);
    tick(); tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    send_spike(3'd5);
    tick();
    tests++; if (req_valid !== 1'b1 || req_r !== 3'd2 || busy !== 1'b1) begin
      fails++; $display("FAIL mid_pending: valid=%b r=%0d busy=%b required 1/2/1", req_valid, req_r, busy);
    end
    rst_n = 1'b0;
    tick();
    tests++; if (req_valid !== 1'b0 || fanout_done !== 1'b0) begin
      fails++; $display("FAIL mid_rst_outputs: valid=%b done=%b required 0/0", req_valid, fanout_done);
    end
    tests++; if (busy !== 1'b0 || spike_ready !== 1'b1) begin
      fails++; $display("FAIL mid_rst_fifo: busy=%b spike_ready=%b required 0/1", busy, spike_ready);
    end
    rst_n = 1'b1;
    collect(30, 0);
    tests++; if (got_q.size() != 0 || done_cnt != 0) begin
      fails++; $display("FAIL mid_after_rst: %0d pairs %0d pulses required 0/0", got_q.size(), done_cnt);
    end
    send_spike(3'd2);
    collect(20, 0);
    tests++; if (got_q.size() != 0 || done_cnt != 1) begin
      fails++; $display("FAIL mid_rows_clear: %0d pairs %0d pulses required 0/1", got_q.size(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fifo_full();
    test_config_hazard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
